// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, word-addressed data memory,
// read-modify-write for sub-word stores, sign/zero-extended sub-word loads.
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        ctrl_mem_read,
  output logic        ctrl_mem_write,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP} state_t;

  state_t      state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_offset;
  logic        lat_unsigned;
  logic [31:0] lat_wdata;
  logic        req_bad;

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] offset, input logic uns);
    logic [31:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (size)
      2'b00:   extract = uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   extract = uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [1:0] size, input logic [1:0] offset);
    logic [31:0] lane;
    lane  = (size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    merge = (old & ~(lane << {offset, 3'b000})) | ((wdata & lane) << {offset, 3'b000});
  endfunction

  assign req_ready = (state == IDLE);

  assign req_bad = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (req_addr >= MEM_BYTES);

  // Strobes are registered and raised on entry to the access state, so each lasts one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      lat_size       <= 2'b00;
      lat_offset     <= 2'b00;
      lat_unsigned   <= 1'b0;
      lat_wdata      <= 32'b0;
      resp_valid     <= 1'b0;
      resp_rdata     <= 32'b0;
      resp_error     <= 1'b0;
      mem_address    <= 32'b0;
      mem_write_data <= 32'b0;
      ctrl_mem_read  <= 1'b0;
      ctrl_mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_size     <= req_size;
            lat_offset   <= req_addr[1:0];
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata;
            mem_address  <= {2'b00, req_addr[31:2]};
            if (req_bad) begin
              resp_error <= 1'b1;
              resp_rdata <= 32'b0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else if (!req_write) begin
              ctrl_mem_read <= 1'b1;
              state         <= LOAD;
            end else if (req_size == 2'b10) begin
              ctrl_mem_write <= 1'b1;
              mem_write_data <= req_wdata;
              state          <= STORE;
            end else begin
              ctrl_mem_read <= 1'b1;
              state         <= RMW_RD;
            end
          end
        end
        LOAD: begin
          ctrl_mem_read <= 1'b0;
          resp_rdata    <= extract(mem_read_data, lat_size, lat_offset, lat_unsigned);
          resp_error    <= 1'b0;
          resp_valid    <= 1'b1;
          state         <= RESP;
        end
        STORE: begin
          ctrl_mem_write <= 1'b0;
          resp_rdata     <= 32'b0;
          resp_error     <= 1'b0;
          resp_valid     <= 1'b1;
          state          <= RESP;
        end
        RMW_RD: begin
          ctrl_mem_read  <= 1'b0;
          ctrl_mem_write <= 1'b1;
          mem_write_data <= merge(mem_read_data, lat_wdata, lat_size, lat_offset);
          state          <= RMW_WR;
        end
        RMW_WR: begin
          ctrl_mem_write <= 1'b0;
          resp_rdata     <= 32'b0;
          resp_error     <= 1'b0;
          resp_valid     <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests checked against
// an arithmetic byte-lane memory model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        ctrl_mem_read;
  logic        ctrl_mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] env_mem [64];
  logic [31:0] ref_mem [64];
  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .ctrl_mem_read(ctrl_mem_read),
    .ctrl_mem_write(ctrl_mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  // Memory the DUT talks to: combinational read, write on posedge.
  assign mem_read_data = env_mem[mem_address[5:0]];
  always @(posedge clock) begin
    if (reset && ctrl_mem_write) env_mem[mem_address[5:0]] <= mem_write_data;
  end

  always @(posedge clock) begin
    if (ctrl_mem_read) rd_cnt++;
    if (ctrl_mem_write) wr_cnt++;
    if (ctrl_mem_read || ctrl_mem_write) begin
      checks++;
      if (ctrl_mem_read && ctrl_mem_write) begin
        errors++;
        $display("[TB] FAIL strobe_exclusive read=%b write=%b required not both high",
                 ctrl_mem_read, ctrl_mem_write);
      end
    end
  end

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 3) || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0) || (addr >= 256);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [31:0] addr, input bit uns);
    longint unsigned nbytes, v, m;
    nbytes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    m = 64'd1 << (8 * nbytes);
    v = (longint'(word) >> (8 * (addr % 4))) % m;
    if (!uns && nbytes < 4 && v >= m / 2) v = v + 64'h1_0000_0000 - m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [31:0] addr);
    longint unsigned m, shift, lane_old, res;
    if (sz == 2) return wd;
    m = (sz == 0) ? 64'd256 : 64'd65536;
    shift = 8 * (addr % 4);
    lane_old = (longint'(old) >> shift) % m;
    res = longint'(old) - (lane_old << shift) + ((longint'(wd) % m) << shift);
    return res[31:0];
  endfunction

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wd, input bit ack, output logic [31:0] rdata,
                        output bit err, output int lat, output int rds, output int wrs);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    rd_cnt = 0; wr_cnt = 0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("[TB] FAIL resp_timeout addr=%h resp_valid=%b required 1 within 20 cycles", addr, resp_valid);
    end
    rdata = resp_rdata; err = resp_error; rds = rd_cnt; wrs = wr_cnt;
    if (ack) begin
      resp_ready = 1'b1;
      @(posedge clock); #1;
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({resp_valid, resp_error, ctrl_mem_read, ctrl_mem_write, req_ready} !== 5'b00001) begin
      errors++;
      $display("[TB] FAIL reset_flags got=%b required 00001",
               {resp_valid, resp_error, ctrl_mem_read, ctrl_mem_write, req_ready});
    end
    checks++;
    if ({resp_rdata, mem_address, mem_write_data} !== 96'b0) begin
      errors++;
      $display("[TB] FAIL reset_data rdata=%h addr=%h wdata=%h required all 0",
               resp_rdata, mem_address, mem_write_data);
    end
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (ctrl_mem_read !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_accept read=%b resp_valid=%b required 0 0", ctrl_mem_read, resp_valid);
    end
    req_valid = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [31:0] rd; bit er; int lat, rds, wrs;
    do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, rd, er, lat, rds, wrs);
    ref_mem[4] = 32'hDEADBEEF;
    checks++;
    if (er !== 1'b0 || lat != 2 || rds != 0 || wrs != 1) begin
      errors++;
      $display("[TB] FAIL sw_access err=%b lat=%0d rds=%0d wrs=%0d required 0 2 0 1", er, lat, rds, wrs);
    end
    checks++;
    if (env_mem[4] !== 32'hDEADBEEF || mem_address !== 32'd4) begin
      errors++;
      $display("[TB] FAIL sw_data mem=%h addr=%h required DEADBEEF 4", env_mem[4], mem_address);
    end
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 1, rd, er, lat, rds, wrs);
    checks++;
    if (rd !== 32'hDEADBEEF || lat != 2 || rds != 1 || wrs != 0) begin
      errors++;
      $display("[TB] FAIL lw rdata=%h lat=%0d rds=%0d wrs=%0d required DEADBEEF 2 1 0", rd, lat, rds, wrs);
    end
    do_req(0, 2'b00, 0, 32'h13, 32'h0, 1, rd, er, lat, rds, wrs);
    checks++;
    if (rd !== 32'hFFFFFFDE) begin
      errors++; $display("[TB] FAIL lb rdata=%h required FFFFFFDE", rd);
    end
    do_req(0, 2'b00, 1, 32'h13, 32'h0, 1, rd, er, lat, rds, wrs);
    checks++;
    if (rd !== 32'h000000DE) begin
      errors++; $display("[TB] FAIL lbu rdata=%h required 000000DE", rd);
    end
    do_req(0, 2'b01, 0, 32'h10, 32'h0, 1, rd, er, lat, rds, wrs);
    checks++;
    if (rd !== 32'hFFFFBEEF) begin
      errors++; $display("[TB] FAIL lh rdata=%h required FFFFBEEF", rd);
    end
    do_req(1, 2'b00, 0, 32'h11, 32'h55, 1, rd, er, lat, rds, wrs);
    ref_mem[4] = 32'hDEAD55EF;
    checks++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 3 || rds != 1 || wrs != 1) begin
      errors++;
      $display("[TB] FAIL sb_rmw err=%b rdata=%h lat=%0d rds=%0d wrs=%0d required 0 0 3 1 1",
               er, rd, lat, rds, wrs);
    end
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 1, rd, er, lat, rds, wrs);
    checks++;
    if (rd !== 32'hDEAD55EF) begin
      errors++; $display("[TB] FAIL lw_after_sb rdata=%h required DEAD55EF", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; bit er; int lat, rds, wrs;
    logic [31:0] addrs [4] = '{32'h12, 32'h01, 32'h100, 32'h20};
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    bit          wrs_in [4] = '{0, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      do_req(wrs_in[i], sizes[i], 0, addrs[i], 32'hFFFF_FFFF, 1, rd, er, lat, rds, wrs);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 1 || rds != 0 || wrs != 0) begin
        errors++;
        $display("[TB] FAIL reject_%0d err=%b rdata=%h lat=%0d rds=%0d wrs=%0d required 1 0 1 0 0",
                 i, er, rd, lat, rds, wrs);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; bit er; int lat, rds, wrs;
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 0, rd, er, lat, rds, wrs);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD55EF || req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_%0d valid=%b rdata=%h ready=%b required 1 DEAD55EF 0",
                 i, resp_valid, resp_rdata, req_ready);
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checks++;
    if (env_mem[4] !== 32'hDEAD55EF || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release mem=%h valid=%b required DEAD55EF 0", env_mem[4], resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; bit er; int lat, rds, wrs;
    do_req(1, 2'b01, 0, 32'h22, 32'hCAFE_A5A5, 1, rd, er, lat, rds, wrs);
    ref_mem[8] = ref_store(ref_mem[8], 32'hCAFE_A5A5, 2'b01, 32'h22);
    checks++;
    if (req_ready !== 1'b1 || lat != 3) begin
      errors++; $display("[TB] FAIL b2b_ready ready=%b lat=%0d required 1 3", req_ready, lat);
    end
    do_req(0, 2'b01, 1, 32'h22, 32'h0, 1, rd, er, lat, rds, wrs);
    checks++;
    if (rd !== 32'h0000A5A5 || lat != 2) begin
      errors++; $display("[TB] FAIL b2b_load rdata=%h lat=%0d required 0000A5A5 2", rd, lat);
    end
  endtask

  task automatic test_reset_abort();
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h77;
    wr_cnt = 0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    checks++;
    if (ctrl_mem_read !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_in_rmw read=%b required 1", ctrl_mem_read);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ctrl_mem_read, ctrl_mem_write, resp_valid, req_ready} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL abort_drop got=%b required 0001",
               {ctrl_mem_read, ctrl_mem_write, resp_valid, req_ready});
    end
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (env_mem[8] !== ref_mem[8] || wr_cnt != 0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_after mem=%h wrs=%0d ready=%b valid=%b required %h 0 1 0",
               env_mem[8], wr_cnt, req_ready, resp_valid, ref_mem[8]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd; bit er, exp_er, wr, uns; int lat, rds, wrs, exp_lat, exp_rds, exp_wrs;
    logic [1:0] sz;
    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) addr = 32'd256 + 32'($urandom_range(0, 300));
      else addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
      exp_er = ref_err(sz, addr);
      exp_rd = 32'h0;
      if (exp_er) begin exp_lat = 1; exp_rds = 0; exp_wrs = 0; end
      else if (!wr) begin
        exp_lat = 2; exp_rds = 1; exp_wrs = 0;
        exp_rd = ref_load(ref_mem[addr[7:2]], sz, addr, uns);
      end else begin
        exp_lat = (sz == 2) ? 2 : 3; exp_rds = (sz == 2) ? 0 : 1; exp_wrs = 1;
        ref_mem[addr[7:2]] = ref_store(ref_mem[addr[7:2]], wd, sz, addr);
      end
      do_req(wr, sz, uns, addr, wd, 1, rd, er, lat, rds, wrs);
      checks++;
      if (er !== exp_er || rd !== exp_rd || lat != exp_lat || rds != exp_rds || wrs != exp_wrs) begin
        errors++;
        $display("[TB] FAIL rand_%0d wr=%b sz=%0d addr=%h got err=%b rd=%h lat=%0d r=%0d w=%0d required %b %h %0d %0d %0d",
                 n, wr, sz, addr, er, rd, lat, rds, wrs, exp_er, exp_rd, exp_lat, exp_rds, exp_wrs);
      end
      if (wr && !exp_er) begin
        checks++;
        if (env_mem[addr[7:2]] !== ref_mem[addr[7:2]]) begin
          errors++;
          $display("[TB] FAIL rand_mem_%0d word=%0d got=%h required %h",
                   n, addr[7:2], env_mem[addr[7:2]], ref_mem[addr[7:2]]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
